// File: rtl/fetch_controller.sv
// Instruction-fetch sequencer for the IF stage: one read per PC over a valid/ready request
// channel, latches the returned word and signals IF_DONE; abandons in-flight fetches on flush.
module fetch_controller #(
  parameter int unsigned         ADDR_W   = 32,
  parameter int unsigned         DATA_W   = 32,
  parameter logic [DATA_W-1:0]   NOP_INST = 32'h0000_0013
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc,
  input  logic              MEM_DONE,
  input  logic              stall,
  input  logic              flush,
  output logic              im_req_valid,
  input  logic              im_req_ready,
  output logic [ADDR_W-1:0] im_req_addr,
  input  logic              im_rsp_valid,
  input  logic [DATA_W-1:0] im_rsp_data,
  output logic              IF_DONE,
  output logic [DATA_W-1:0] inst,
  output logic              inst_valid
);

  typedef enum logic [2:0] {StIdle, StReq, StWait, StDone, StDrop} state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   inst_q, inst_d;
  logic                inst_valid_q, inst_valid_d;
  logic                unused_pc_lsb;

  assign unused_pc_lsb = ^pc[1:0];

  always_comb begin
    state_d      = state_q;
    inst_d       = inst_q;
    inst_valid_d = inst_valid_q;
    im_req_valid = 1'b0;
    IF_DONE      = 1'b0;
    unique case (state_q)
      StIdle: state_d = StReq;
      StReq: begin
        im_req_valid = 1'b1;
        if (im_req_ready) state_d = StWait;
      end
      StWait: begin
        // Flush completes the slot immediately; a late response must still be drained.
        if (flush && MEM_DONE) begin
          IF_DONE      = 1'b1;
          inst_valid_d = 1'b0;
          state_d      = im_rsp_valid ? StReq : StDrop;
        end else if (im_rsp_valid) begin
          inst_d       = im_rsp_data;
          inst_valid_d = 1'b1;
          state_d      = StDone;
        end
      end
      StDone: begin
        IF_DONE = 1'b1;
        if (MEM_DONE && (flush || !stall)) begin
          inst_valid_d = 1'b0;
          state_d      = StReq;
        end
      end
      StDrop: begin
        if (im_rsp_valid) state_d = StReq;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      inst_q       <= NOP_INST;
      inst_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      inst_q       <= inst_d;
      inst_valid_q <= inst_valid_d;
    end
  end

  assign im_req_addr = {pc[ADDR_W-1:2], 2'b00};
  assign inst        = inst_valid_q ? inst_q : NOP_INST;
  assign inst_valid  = inst_valid_q;

`ifndef SYNTHESIS
  // A response is only legal while a request is outstanding.
  always_ff @(posedge clk) begin
    if (rst) assert (!im_rsp_valid || state_q == StWait || state_q == StDrop);
  end
`endif

endmodule
